// File: rtl/soft_reset_pkg.sv
// Shared definitions for the soft-reset requester and reset monitor:
// FSM encoding, register map, default key and STATUS bit layout.
package soft_reset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ACK          = 3'd1,
    ST_REQ          = 3'd2,
    ST_WAIT_ASSERT  = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_STATUS   = 4'h1;
  localparam logic [3:0] A_SOFT_CNT = 4'h2;
  localparam logic [3:0] A_LINK_CNT = 4'h3;
  localparam logic [3:0] A_DUR      = 4'h4;

  localparam logic [31:0] DEF_KEY = 32'h5EC0_0DE5;

  localparam int SB_BUSY   = 0;
  localparam int SB_HOLD   = 1;
  localparam int SB_BADKEY = 2;
  localparam int SB_TMO    = 3;
  localparam int SB_STATE  = 4;

  localparam int DUR_BITS = 24;

endpackage

// File: rtl/soft_reset_ctrl_sat_counter.sv
// Saturating up-counter; clear (or reset) has priority over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/soft_reset_ctrl.sv
// Wishbone soft-reset requester and hold-reset monitor.
// Optional WAIT_ASSERT timeout: define SOFT_RESET_TIMEOUT_EN.
module soft_reset_ctrl
  import soft_reset_pkg::*;
#(
  parameter logic [31:0] KEY            = DEF_KEY,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_BITS       = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_data_o,
  input  logic        hold_reset_i,
  input  logic        link_ok_i,
  output logic        soft_reset_o
);

  state_t r_state;
  state_t w_next;

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_bad_key;
  logic        r_tmo;
  logic        r_link_q;
  logic [DUR_BITS-1:0] r_dur;

  logic w_acc, w_wr, w_ctrl_wr;
  logic w_key_wr, w_bad_wr, w_clr;
  logic w_soft_inc, w_link_inc;
  logic w_dur_inc, w_dur_clr, w_dur_done;
  logic w_to_hit, w_busy;
  logic [6:0]  w_status;
  logic [31:0] w_rdata;
  logic [CNT_BITS-1:0] w_soft_cnt;
  logic [CNT_BITS-1:0] w_link_cnt;
  logic [DUR_BITS-1:0] w_dur_cnt;

  // An access is taken only while no ack is outstanding.
  assign w_acc     = wb_stb_i && !r_ack;
  assign w_wr      = w_acc && wb_we_i;
  assign w_ctrl_wr = w_wr && (wb_addr_i == A_CTRL);
  assign w_key_wr  = w_ctrl_wr && (wb_data_i == KEY);
  assign w_bad_wr  = w_ctrl_wr && (wb_data_i != KEY);
  assign w_clr     = w_wr && (wb_addr_i == A_SOFT_CNT);

  assign w_busy     = (r_state != ST_IDLE);
  assign w_soft_inc = w_key_wr && !w_busy;
  assign w_link_inc = r_link_q && !link_ok_i;

  // Duration counter holds zero until hold_reset_i is first seen.
  assign w_dur_clr = (r_state == ST_REQ) ||
                     ((r_state == ST_WAIT_ASSERT) && !hold_reset_i);
  assign w_dur_inc = hold_reset_i &&
                     ((r_state == ST_WAIT_ASSERT) ||
                      (r_state == ST_WAIT_RELEASE));
  assign w_dur_done = (r_state == ST_WAIT_RELEASE) && !hold_reset_i;

`ifdef SOFT_RESET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i || (r_state != ST_WAIT_ASSERT)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_ASSERT) && !hold_reset_i &&
                    (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  sat_counter #(.W(CNT_BITS)) u_soft_cnt (
    .i_clk (clock_i),
    .i_rst (reset_i),
    .i_inc (w_soft_inc),
    .i_clr (w_clr),
    .o_cnt (w_soft_cnt)
  );

  sat_counter #(.W(CNT_BITS)) u_link_cnt (
    .i_clk (clock_i),
    .i_rst (reset_i),
    .i_inc (w_link_inc),
    .i_clr (w_clr),
    .o_cnt (w_link_cnt)
  );

  sat_counter #(.W(DUR_BITS)) u_dur_cnt (
    .i_clk (clock_i),
    .i_rst (reset_i),
    .i_inc (w_dur_inc),
    .i_clr (w_dur_clr),
    .o_cnt (w_dur_cnt)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_key_wr) w_next = ST_ACK;
      end
      ST_ACK: w_next = ST_REQ;
      ST_REQ: w_next = ST_WAIT_ASSERT;
      ST_WAIT_ASSERT: begin
        if (hold_reset_i) w_next = ST_WAIT_RELEASE;
        else if (w_to_hit) w_next = ST_IDLE;
      end
      ST_WAIT_RELEASE: begin
        if (!hold_reset_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status = '0;
    w_status[SB_BUSY]   = w_busy;
    w_status[SB_HOLD]   = hold_reset_i;
    w_status[SB_BADKEY] = r_bad_key;
    w_status[SB_TMO]    = r_tmo;
    w_status[SB_STATE +: 3] = r_state;
  end

  always_comb begin
    w_rdata = '0;
    case (wb_addr_i)
      A_STATUS:   w_rdata = 32'(w_status);
      A_SOFT_CNT: w_rdata = 32'(w_soft_cnt);
      A_LINK_CNT: w_rdata = 32'(w_link_cnt);
      A_DUR:      w_rdata = 32'(r_dur);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_bad_key <= 1'b0;
      r_tmo     <= 1'b0;
      r_link_q  <= 1'b1;
      r_dur     <= '0;
    end else begin
      r_ack    <= w_acc;
      r_rdata  <= (w_acc && !wb_we_i) ? w_rdata : '0;
      r_link_q <= link_ok_i;
      if (w_clr) r_bad_key <= 1'b0;
      else if (w_bad_wr) r_bad_key <= 1'b1;
      if (w_clr) r_tmo <= 1'b0;
      else if (w_to_hit) r_tmo <= 1'b1;
      if (w_clr) r_dur <= '0;
      else if (w_dur_done) r_dur <= w_dur_cnt;
    end
  end

  assign wb_ack_o     = r_ack;
  assign wb_data_o    = r_rdata;
  assign soft_reset_o = (r_state == ST_REQ);

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// Bench for soft_reset_ctrl: timestamp-based reference model checked
// every cycle, plus directed bus transactions with literal expectations.
module tb_soft_reset_ctrl;

  localparam int CB = 8;
  localparam int TO = 16;
  localparam logic [31:0] K = 32'h5EC0_0DE5;
  localparam int CMAX = (1 << CB) - 1;
  localparam int DMAX = (1 << 24) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic hold = 1'b0;
  logic link = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [31:0] wdat = 32'h0;
  logic ack, srst;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  soft_reset_ctrl #(
    .KEY(K),
    .TIMEOUT_CYCLES(TO),
    .CNT_BITS(CB)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_addr_i    (addr),
    .wb_data_i    (wdat),
    .wb_ack_o     (ack),
    .wb_data_o    (rdat),
    .hold_reset_i (hold),
    .link_ok_i    (link),
    .soft_reset_o (srst)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_strobe = 0;

  bit m_valid = 1'b0;
  bit e_ack, e_srst;
  logic [31:0] e_data;
  int m_soft, m_link, m_dur, m_tacc, m_hlen;
  bit m_bad, m_tmo, m_lprev, m_busy, m_seen;

  // Spec state code as a function of time since the keyed write.
  function automatic int m_code(int k);
    if (!m_busy) return 0;
    if (k == m_tacc + 1) return 1;
    if (k == m_tacc + 2) return 2;
    return m_seen ? 4 : 3;
  endfunction

  always @(posedge clk) begin : model
    int code;
    bit acc, was_busy;
    logic [31:0] rd;
    if (rst) begin
      m_soft = 0; m_link = 0; m_dur = 0;
      m_bad = 0; m_tmo = 0; m_lprev = 1;
      m_busy = 0; m_seen = 0; m_tacc = -10; m_hlen = 0;
      e_ack = 0; e_data = 0; e_srst = 0;
    end else begin
      code = m_code(cyc);
      acc = stb && !e_ack;
      case (addr)
        4'h1: rd = {25'd0, code[2:0], m_tmo, m_bad, hold, code != 0};
        4'h2: rd = 32'(m_soft);
        4'h3: rd = 32'(m_link);
        4'h4: rd = 32'(m_dur);
        default: rd = 32'h0;
      endcase
      e_data = (acc && !we) ? rd : 32'h0;
      e_srst = m_busy && (cyc == m_tacc + 1);
      was_busy = m_busy;
      if (m_busy && code >= 3) begin
        if (!m_seen) begin
          if (hold) begin
            m_seen = 1; m_hlen = 1;
          end
`ifdef SOFT_RESET_TIMEOUT_EN
          else if (cyc - (m_tacc + 3) == TO - 1) begin
            m_busy = 0; m_tmo = 1;
          end
`endif
        end else if (hold) begin
          if (m_hlen < DMAX) m_hlen++;
        end else begin
          m_dur = m_hlen; m_busy = 0;
        end
      end
      if (m_lprev && !link && m_link < CMAX) m_link++;
      m_lprev = link;
      if (acc && we && addr == 4'h0) begin
        if (wdat == K) begin
          if (!was_busy) begin
            m_busy = 1; m_tacc = cyc; m_seen = 0;
            if (m_soft < CMAX) m_soft++;
          end
        end else begin
          m_bad = 1;
        end
      end
      if (acc && we && addr == 4'h2) begin
        m_soft = 0; m_link = 0; m_dur = 0; m_bad = 0; m_tmo = 0;
      end
      e_ack = acc;
    end
    m_valid = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if ({ack, srst, rdat} !== {e_ack, e_srst, e_data}) begin
        n_bad++;
        $display("FAIL model cyc=%0d ack=%b/%b srst=%b/%b data=%h/%h (dut/model)",
                 cyc, ack, e_ack, srst, e_srst, rdat, e_data);
      end
      if (srst === 1'b1) n_strobe++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bus(input bit w, input logic [3:0] a,
                     input logic [31:0] d, output logic [31:0] q,
                     output int n);
    stb = 1'b1; we = w; addr = a; wdat = d;
    q = 32'hDEAD_BEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 8);
    if (ack !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout addr=%h: no ack in %0d cycles", a, n);
    end
    q = rdat;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    int n;
    bus(1'b1, a, d, q, n);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] q;
    int n;
    bus(1'b0, a, 32'h0, q, n);
    chk(nm, q, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_srst", 32'(srst), 32'h0);
    chk("reset_data", rdat, 32'h0);
    rd_chk("reset_status", 4'h1, 32'h0);
    repeat (2) @(negedge clk);

    bus(1'b1, 4'h0, K, q, n);
    chk("key_ack_latency", 32'(n), 32'd1);
    chk("strobe_not_yet", 32'(n_strobe), 32'd0);
    rd_chk("soft_cnt_1", 4'h2, 32'd1);
    chk("strobe_once", 32'(n_strobe), 32'd1);
    rd_chk("status_wait_assert", 4'h1, 32'h31);

    fork
      begin
        hold = 1'b1;
        repeat (300) @(negedge clk);
        hold = 1'b0;
      end
      begin
        repeat (50) @(negedge clk);
        wr(4'h0, K);
        rd_chk("status_wait_release", 4'h1, 32'h43);
      end
    join
    repeat (4) @(negedge clk);
    rd_chk("dur_300", 4'h4, 32'd300);
    rd_chk("status_idle", 4'h1, 32'h0);
    rd_chk("soft_cnt_still_1", 4'h2, 32'd1);
    chk("no_second_strobe", 32'(n_strobe), 32'd1);

    wr(4'h0, 32'h1234_5678);
    repeat (4) @(negedge clk);
    chk("bad_key_no_strobe", 32'(n_strobe), 32'd1);
    rd_chk("status_bad_key", 4'h1, 32'h04);
    rd_chk("unmapped_read", 4'h9, 32'h0);
    wr(4'h2, 32'h0);
    rd_chk("status_cleared", 4'h1, 32'h0);
    rd_chk("soft_cnt_cleared", 4'h2, 32'h0);
    rd_chk("dur_cleared", 4'h4, 32'h0);

    for (int i = 0; i < 3; i++) begin
      link = 1'b0; @(negedge clk);
      link = 1'b1; @(negedge clk);
    end
    rd_chk("link_cnt_3", 4'h3, 32'd3);
    for (int i = 0; i < 260; i++) begin
      link = 1'b0; @(negedge clk);
      link = 1'b1; @(negedge clk);
    end
    rd_chk("link_cnt_sat", 4'h3, 32'(CMAX));

    wr(4'h0, K);
    repeat (40) @(negedge clk);
`ifdef SOFT_RESET_TIMEOUT_EN
    rd_chk("status_timeout", 4'h1, 32'h08);
    chk("timeout_strobe", 32'(n_strobe), 32'd2);
    wr(4'h0, K);
    repeat (6) @(negedge clk);
    chk("strobe_3", 32'(n_strobe), 32'd3);
`else
    rd_chk("status_wait_forever", 4'h1, 32'h31);
    chk("strobe_2", 32'(n_strobe), 32'd2);
`endif
    hold = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("status_release_pre_rst", 4'h1, 32'h43);
    n = n_strobe;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("status_after_rst", 4'h1, 32'h02);
    rd_chk("soft_cnt_after_rst", 4'h2, 32'h0);
    rd_chk("link_cnt_after_rst", 4'h3, 32'h0);
    rd_chk("dur_after_rst", 4'h4, 32'h0);
    hold = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_strobe_after_rst", 32'(n_strobe), 32'(n));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
